// File: rtl/multiport_regfile_scrub.sv
// Architectural register file with N read / M write ports, a hard-wired zero register,
// optional write-to-read bypass and a sequential one-entry-per-cycle scrub engine.
module multiport_regfile_scrub #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NWR-1:0]                      wr_en,
    input  logic [NWR-1:0][$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NWR-1:0][WIDTH-1:0]           wr_data,
    input  logic [NRD-1:0][$clog2(DEPTH)-1:0]   rd_addr,
    output logic [NRD-1:0][WIDTH-1:0]           rd_data,
    input  logic                                scrub_req,
    output logic                                scrub_busy,
    output logic                                scrub_done,
    output logic                                wr_conflict,
    output logic                                wr_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCRUB = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     scrub_cnt_q, scrub_cnt_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic              wr_conflict_q, wr_conflict_d;
    logic              wr_dropped_q, wr_dropped_d;
    logic              wr_accept_s;
    logic              bypass_en_s;

    // Writes land in IDLE and DONE; bypass is only offered while IDLE
    assign wr_accept_s = (state_q != ST_SCRUB);
    assign bypass_en_s = (BYPASS != 0) && (state_q == ST_IDLE);

    // Scrub sequencer next-state and counter
    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (scrub_req) begin
                    state_d     = ST_SCRUB;
                    scrub_cnt_d = '0;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SCRUB: begin
                // Counter parks at zero on the last entry rather than wrapping
                if (scrub_cnt_q == LAST_A) begin
                    state_d     = ST_DONE;
                    scrub_cnt_d = '0;
                end else begin
                    scrub_cnt_d = scrub_cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (scrub_req) begin
                    state_d     = ST_SCRUB;
                    scrub_cnt_d = '0;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                scrub_cnt_d = '0;
            end
        endcase
    end

    // Array next-state: scrub clear, or port writes with highest port winning
    always_comb begin
        regs_d = regs_q;
        if (!wr_accept_s) begin
            regs_d[scrub_cnt_q] = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] != ZERO_A)) begin
                    regs_d[wr_addr[k]] = wr_data[k];
                end else begin
                    regs_d[wr_addr[k]] = regs_d[wr_addr[k]];
                end
            end
        end
    end

    // Status pulses for the following cycle
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                wr_conflict_d = wr_conflict_d |
                    (wr_en[a] && wr_en[b] && (wr_addr[a] == wr_addr[b]) && (wr_addr[a] != ZERO_A));
            end
        end
        wr_dropped_d = (!wr_accept_s) && (|wr_en);
    end

    // Read ports with optional same-cycle forwarding; zero register always reads 0
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_data[j] = regs_q[rd_addr[j]];
            for (int k = 0; k < NWR; k++) begin
                rd_data[j] = (bypass_en_s && wr_en[k] && (wr_addr[k] == rd_addr[j]))
                             ? wr_data[k] : rd_data[j];
            end
            rd_data[j] = (rd_addr[j] == ZERO_A) ? '0 : rd_data[j];
        end
    end

    // State, array and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            scrub_cnt_q   <= '0;
            wr_conflict_q <= 1'b0;
            wr_dropped_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            scrub_cnt_q   <= scrub_cnt_d;
            wr_conflict_q <= wr_conflict_d;
            wr_dropped_q  <= wr_dropped_d;
            regs_q        <= regs_d;
        end
    end

    assign scrub_busy  = (state_q == ST_SCRUB);
    assign scrub_done  = (state_q == ST_DONE);
    assign wr_conflict = wr_conflict_q;
    assign wr_dropped  = wr_dropped_q;

endmodule

// File: tb/tb_multiport_regfile_scrub.sv
// Directed bench for multiport_regfile_scrub: vector table for ports/bypass/conflicts,
// hand sequences for reset, full scrub, writes during scrub and reset mid-scrub.
`timescale 1ns/100ps
module tb_multiport_regfile_scrub;

    logic              clk;
    logic              reset;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][63:0]  wr_data;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][63:0]  rd_data;
    logic              scrub_req;
    logic              scrub_busy;
    logic              scrub_done;
    logic              wr_conflict;
    logic              wr_dropped;

    int n_cmp = 0;
    int n_err = 0;

    multiport_regfile_scrub dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .scrub_req   (scrub_req),
        .scrub_busy  (scrub_busy),
        .scrub_done  (scrub_done),
        .wr_conflict (wr_conflict),
        .wr_dropped  (wr_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [63:0] wd0;
        logic [63:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic        econf;
        logic        edrop;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                                input logic [63:0] wd0, input logic [63:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [63:0] e0, input logic [63:0] e1,
                                input logic econf, input logic edrop);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.econf = econf; v.edrop = edrop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        reset = 1'b0; wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        rd_addr = '0; scrub_req = 1'b0;

        tbl[0]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd0,  5'd5,  64'h0,  64'h0,  1'b0, 1'b0);
        tbl[1]  = mk(2'b01, 5'd31, 5'd0,  64'hDEAD_BEEF, 64'h0,  5'd31, 5'd3,  64'h0,  64'h0,  1'b0, 1'b0);
        tbl[2]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd31, 5'd0,  64'h0,  64'h0,  1'b0, 1'b0);
        tbl[3]  = mk(2'b01, 5'd3,  5'd0,  64'h1F,        64'h0,  5'd3,  5'd31, 64'h1F, 64'h0,  1'b0, 1'b0);
        tbl[4]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd3,  5'd4,  64'h1F, 64'h0,  1'b0, 1'b0);
        tbl[5]  = mk(2'b11, 5'd5,  5'd5,  64'hAA,        64'hBB, 5'd5,  5'd3,  64'hBB, 64'h1F, 1'b0, 1'b0);
        tbl[6]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd5,  5'd3,  64'hBB, 64'h1F, 1'b1, 1'b0);
        tbl[7]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd5,  5'd0,  64'hBB, 64'h0,  1'b0, 1'b0);
        tbl[8]  = mk(2'b11, 5'd31, 5'd31, 64'hAA,        64'hBB, 5'd31, 5'd5,  64'h0,  64'hBB, 1'b0, 1'b0);
        tbl[9]  = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd5,  5'd31, 64'hBB, 64'h0,  1'b0, 1'b0);
        tbl[10] = mk(2'b11, 5'd7,  5'd8,  64'h70,        64'h80, 5'd8,  5'd7,  64'h80, 64'h70, 1'b0, 1'b0);
        tbl[11] = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd7,  5'd8,  64'h70, 64'h80, 1'b0, 1'b0);
        tbl[12] = mk(2'b10, 5'd7,  5'd9,  64'h12,        64'h99, 5'd7,  5'd9,  64'h70, 64'h99, 1'b0, 1'b0);
        tbl[13] = mk(2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  5'd9,  5'd7,  64'h99, 64'h70, 1'b0, 1'b0);
        tbl[14] = mk(2'b01, 5'd4,  5'd0,  64'h44,        64'h0,  5'd3,  5'd4,  64'h1F, 64'h44, 1'b0, 1'b0);

        // Reset held two cycles, then every index reads zero
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, scrub_busy}, 64'd0);
        chk("rst_done", {63'd0, scrub_done}, 64'd0);
        chk("rst_conf", {63'd0, wr_conflict}, 64'd0);
        chk("rst_drop", {63'd0, wr_dropped}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr[0] = 5'(i);
            #0.2;
            chk($sformatf("rst_rd%0d", i), rd_data[0], 64'd0);
        end

        // Table of port/bypass/conflict vectors
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            wr_en = tbl[i].we; wr_addr[0] = tbl[i].wa0; wr_addr[1] = tbl[i].wa1;
            wr_data[0] = tbl[i].wd0; wr_data[1] = tbl[i].wd1;
            rd_addr[0] = tbl[i].ra0; rd_addr[1] = tbl[i].ra1;
            #2;
            chk($sformatf("v%0d_rd0", i), rd_data[0], tbl[i].e0);
            chk($sformatf("v%0d_rd1", i), rd_data[1], tbl[i].e1);
            chk($sformatf("v%0d_conf", i), {63'd0, wr_conflict}, {63'd0, tbl[i].econf});
            chk($sformatf("v%0d_drop", i), {63'd0, wr_dropped}, {63'd0, tbl[i].edrop});
            chk($sformatf("v%0d_busy", i), {63'd0, scrub_busy}, 64'd0);
        end
        @(posedge clk); #1;
        wr_en = 2'b00;

        // Fill idx 0..30 with their own index
        for (int i = 0; i < 31; i++) begin
            wr_en = 2'b01; wr_addr[0] = 5'(i); wr_data[0] = 64'(i);
            @(posedge clk); #1;
        end
        wr_en = 2'b00;
        scrub_req = 1'b1;
        @(posedge clk); #1;
        scrub_req = 1'b0;

        // Full scrub: progress, dropped write, DONE-cycle write
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            wr_en = 2'b00; rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
            if (c == 15 || c == 32) begin
                wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 64'h55;
                rd_addr[0] = 5'd20; rd_addr[1] = 5'd7;
            end
            if (c == 33) rd_addr[0] = 5'd7;
            #2;
            if (scrub_busy) busy_cnt++;
            if (scrub_done) done_cnt++;
            if (c == 10) begin
                for (int i = 0; i <= 10; i++) begin
                    rd_addr[0] = 5'(i);
                    #0.2;
                    chk($sformatf("scr10_rd%0d", i), rd_data[0], (i == 10) ? 64'd10 : 64'd0);
                end
            end
            if (c == 15) begin
                chk("scr_nobypass", rd_data[1], 64'd0);
                chk("scr_rd20", rd_data[0], 64'd20);
                chk("scr_drop15", {63'd0, wr_dropped}, 64'd0);
            end
            if (c == 16) chk("scr_drop16", {63'd0, wr_dropped}, 64'd1);
            if (c == 17) chk("scr_drop17", {63'd0, wr_dropped}, 64'd0);
            if (c == 32) begin
                chk("done_pulse", {63'd0, scrub_done}, 64'd1);
                chk("done_busy", {63'd0, scrub_busy}, 64'd0);
            end
            if (c == 33) begin
                chk("done_wr_stored", rd_data[0], 64'h55);
                chk("done_drop", {63'd0, wr_dropped}, 64'd0);
                chk("done_gone", {63'd0, scrub_done}, 64'd0);
                for (int i = 0; i < 32; i++) begin
                    if (i != 7) begin
                        rd_addr[1] = 5'(i);
                        #0.2;
                        chk($sformatf("post_rd%0d", i), rd_data[1], 64'd0);
                    end
                end
            end
            @(posedge clk); #1;
        end
        wr_en = 2'b00;
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        chk("done_count", 64'(done_cnt), 64'd1);

        // Reset mid-scrub
        wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 64'h20;
        @(posedge clk); #1;
        wr_en = 2'b00; scrub_req = 1'b1;
        @(posedge clk); #1;
        scrub_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            wr_en = 2'b00; reset = 1'b1; rd_addr[0] = 5'd7; rd_addr[1] = 5'd20;
            if (c == 5) reset = 1'b0;
            if (c == 6) begin
                wr_en = 2'b01; wr_addr[0] = 5'd2; wr_data[0] = 64'h22;
            end
            if (c == 7) rd_addr[0] = 5'd2;
            #2;
            if (scrub_busy) busy_cnt++;
            if (scrub_done) done_cnt++;
            if (c == 5) chk("mid_rd7_pre", rd_data[0], 64'h55);
            if (c == 6) begin
                chk("mid_busy", {63'd0, scrub_busy}, 64'd0);
                chk("mid_rd7", rd_data[0], 64'd0);
                chk("mid_rd20", rd_data[1], 64'd0);
            end
            if (c == 7) chk("mid_wr_after", rd_data[0], 64'h22);
            @(posedge clk); #1;
        end
        chk("mid_busy_cycles", 64'(busy_cnt), 64'd6);
        chk("mid_no_done", 64'(done_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiport_regfile_scrub.md
Name: multiport_regfile_scrub

Overview:
Parametrised architectural register file for the out-of-order core. It generalises the fixed 32x64 single-write array to N read ports and M write ports, with a hard-wired zero register and optional write-to-read bypass. A sequenced scrub engine clears the array one entry per cycle on request, so pipeline flush does not need a wide parallel clear.

Parameters:
WIDTH, 64, data bits per register
DEPTH, 32, number of registers (power of two, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports
ZERO_IDX, 31, index of the constant-zero register
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low; reset=0 at a posedge resets all state
wr_en  input  NWR  per-port write enable
wr_addr  input  NWR x log2(DEPTH)  per-port write index
wr_data  input  NWR x WIDTH  per-port write data
rd_addr  input  NRD x log2(DEPTH)  per-port read index
rd_data  output  NRD x WIDTH  per-port read data, combinational
scrub_req  input  1  start a full-array clear
scrub_busy  output  1  high while scrub is in progress
scrub_done  output  1  one-cycle pulse after the final entry is cleared
wr_conflict  output  1  registered pulse: two or more enabled write ports targeted the same non-zero index in the previous cycle
wr_dropped  output  1  registered pulse: at least one enabled write was discarded by scrub in the previous cycle

Behaviour:
- Reset (reset=0 at posedge): all registers 0, FSM IDLE, scrub counter 0, scrub_busy/scrub_done/wr_conflict/wr_dropped 0. Reset mid-scrub aborts the scrub with no scrub_done pulse.
- Writes (IDLE): at posedge, each port k with wr_en[k]=1 writes wr_data[k] into reg[wr_addr[k]]. Latency 1 cycle to the stored value.
- Multiple ports, same index: the highest-numbered enabled port wins. wr_conflict=1 in the following cycle only. Writes to ZERO_IDX do not count toward conflicts.
- Zero register: writes to ZERO_IDX are discarded silently. Reads of ZERO_IDX always return 0, including under bypass.
- Reads: rd_data[j] = reg[rd_addr[j]] combinationally.
- Bypass: if BYPASS=1, FSM is IDLE, and some enabled write port targets rd_addr[j] (not ZERO_IDX), rd_data[j] = wr_data of the highest-numbered such port. With BYPASS=0, the new value is visible the cycle after the write.
- FSM IDLE: a posedge with scrub_req=1 enters SCRUB and sets the counter to 0. Writes presented in that same cycle are still performed.
- FSM SCRUB:
  - scrub_busy=1.
  - Each posedge clears reg[counter] and increments the counter.
  - When the counter reaches DEPTH-1 and that entry is cleared, the FSM goes to DONE.
  - SCRUB lasts exactly DEPTH cycles.
  - All writes are ignored; wr_dropped=1 the next cycle if any wr_en was high.
  - Bypass is inactive. Reads return current stored values, partially cleared.
  - scrub_req is ignored.
- FSM DONE: one cycle with scrub_done=1 and scrub_busy=0. Writes are accepted normally. Next state is IDLE, or SCRUB if scrub_req=1, which starts a new scrub immediately.
- The counter is log2(DEPTH) bits and must not wrap mid-scrub.

Test Plan:
- Reset and zero register: hold reset=0 two cycles, release. Read all indices -> 0. Write 64'hDEAD_BEEF to idx 31 -> reads 0; wr_conflict=0.
- Basic write/read, BYPASS=1: port0 writes 64'h1F to idx 3 while rd_addr[0]=3 -> rd_data[0]=64'h1F in the same cycle, and stays 64'h1F after the write is deasserted.
- Write conflict: port0 writes 64'hAA and port1 writes 64'hBB to idx 5 in one cycle -> reg5=64'hBB; wr_conflict pulses 1 for exactly one cycle. Repeat both ports to idx 31 -> no conflict.
- Scrub: fill idx 0..30 with their index value, pulse scrub_req.
  - scrub_busy is high for 32 cycles; at scrub cycle 10, reg0..9 read 0 and reg10 reads 10.
  - scrub_done pulses once; afterwards all reads are 0.
- Write during scrub: wr_en[0]=1, idx 7 = 64'h55 mid-scrub -> value not stored; wr_dropped pulses the next cycle. The same write in the DONE cycle is stored.
- Reset mid-scrub: drive reset=0 at scrub cycle 5 -> scrub_busy=0, no scrub_done; all regs 0; FSM accepts a write on the first cycle after reset=1.
